// File: rtl/md5_pkg.sv
// Shared MD5 definitions: word type, per-step constant tables, round functions,
// rotate helper and message-word schedule used by the step pipeline.
package md5_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned MD5_STEPS = 64;

    // Additive constants K[i] = floor(abs(sin(i+1)) * 2^32)
    localparam word_t MD5_K [MD5_STEPS] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    localparam int unsigned MD5_S [MD5_STEPS] = '{
        7, 12, 17, 22,  7, 12, 17, 22,  7, 12, 17, 22,  7, 12, 17, 22,
        5,  9, 14, 20,  5,  9, 14, 20,  5,  9, 14, 20,  5,  9, 14, 20,
        4, 11, 16, 23,  4, 11, 16, 23,  4, 11, 16, 23,  4, 11, 16, 23,
        6, 10, 15, 21,  6, 10, 15, 21,  6, 10, 15, 21,  6, 10, 15, 21
    };

    function automatic word_t rotl32(input word_t x, input int unsigned s);
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic word_t md5_f(input word_t b, input word_t c, input word_t d);
        return (b & c) | (~b & d);
    endfunction

    function automatic word_t md5_g(input word_t b, input word_t c, input word_t d);
        return (b & d) | (c & ~d);
    endfunction

    function automatic word_t md5_h(input word_t b, input word_t c, input word_t d);
        return b ^ c ^ d;
    endfunction

    function automatic word_t md5_i(input word_t b, input word_t c, input word_t d);
        return c ^ (b | ~d);
    endfunction

    // Index of the message word consumed by step i.
    function automatic logic [3:0] md5_msg_idx(input int unsigned i);
        int unsigned idx;
        if (i < 16)      idx = i;
        else if (i < 32) idx = (5 * i + 1) % 16;
        else if (i < 48) idx = (3 * i + 5) % 16;
        else             idx = (7 * i) % 16;
        return idx[3:0];
    endfunction

endpackage

// File: rtl/md5_step_stage.sv
// One MD5 compression step as a single registered pipeline stage.
// Latency: 1 cycle. Backpressure: none; accepts a new step every cycle.
// Data registers hold on idle cycles; o_valid follows i_valid each edge.
module md5_step_stage
    import md5_pkg::*;
#(
    parameter int unsigned ROUND     = 0,
    parameter word_t       T_CONST   = 32'hd76aa478,
    parameter int unsigned LROT_BITS = 7
) (
    input  logic  clk,
    input  logic  reset,
    input  word_t message,
    input  logic  i_valid,
    input  word_t i_a,
    input  word_t i_b,
    input  word_t i_c,
    input  word_t i_d,
    output logic  o_valid,
    output word_t o_a,
    output word_t o_b,
    output word_t o_c,
    output word_t o_d
);

    word_t w_fn;
    word_t w_sum;
    word_t w_rot;

    logic  r_valid;
    word_t r_a;
    word_t r_b;
    word_t r_c;
    word_t r_d;

    if (ROUND > 63) begin : g_bad_round
        $fatal(1, "md5_step_stage: ROUND must be 0..63");
    end

    if (LROT_BITS < 1 || LROT_BITS > 31) begin : g_bad_rot
        $fatal(1, "md5_step_stage: LROT_BITS must be 1..31");
    end

    if (ROUND < 16) begin : g_fn_f
        assign w_fn = md5_f(i_b, i_c, i_d);
    end else if (ROUND < 32) begin : g_fn_g
        assign w_fn = md5_g(i_b, i_c, i_d);
    end else if (ROUND < 48) begin : g_fn_h
        assign w_fn = md5_h(i_b, i_c, i_d);
    end else begin : g_fn_i
        assign w_fn = md5_i(i_b, i_c, i_d);
    end

    assign w_sum = i_a + w_fn + message + T_CONST;
    // Constant rotate: pure wiring, no shifter.
    assign w_rot = {w_sum[31-LROT_BITS:0], w_sum[31:32-LROT_BITS]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_a <= i_d;
                r_b <= i_b + w_rot;
                r_c <= i_b;
                r_d <= i_c;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_c     = r_c;
    assign o_d     = r_d;

endmodule

// File: tb/tb_md5_step_stage.sv
// Bench for md5_step_stage: four instances (one per round group) share inputs and
// are compared against a step-level MD5 reference model each cycle.
module tb_md5_step_stage;

    localparam int NI = 4;
    localparam int          RND [NI] = '{0, 16, 32, 48};
    localparam logic [31:0] TC  [NI] = '{32'hd76aa478, 32'hf61e2562, 32'hfffa3942, 32'hf4292244};
    localparam int          SH  [NI] = '{7, 5, 4, 6};

    logic        clk;
    logic        reset;
    logic [31:0] message;
    logic        i_valid;
    logic [31:0] i_a, i_b, i_c, i_d;

    logic        ov [NI];
    logic [31:0] oa [NI];
    logic [31:0] ob [NI];
    logic [31:0] oc [NI];
    logic [31:0] od [NI];

    logic        ev [NI];
    logic [31:0] ea [NI];
    logic [31:0] eb [NI];
    logic [31:0] ec [NI];
    logic [31:0] ed [NI];

    int vectors;
    int miscompares;

    md5_step_stage #(.ROUND(0), .T_CONST(32'hd76aa478), .LROT_BITS(7)) u_r0 (
        .clk(clk), .reset(reset), .message(message), .i_valid(i_valid),
        .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_d(i_d),
        .o_valid(ov[0]), .o_a(oa[0]), .o_b(ob[0]), .o_c(oc[0]), .o_d(od[0]));

    md5_step_stage #(.ROUND(16), .T_CONST(32'hf61e2562), .LROT_BITS(5)) u_r16 (
        .clk(clk), .reset(reset), .message(message), .i_valid(i_valid),
        .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_d(i_d),
        .o_valid(ov[1]), .o_a(oa[1]), .o_b(ob[1]), .o_c(oc[1]), .o_d(od[1]));

    md5_step_stage #(.ROUND(32), .T_CONST(32'hfffa3942), .LROT_BITS(4)) u_r32 (
        .clk(clk), .reset(reset), .message(message), .i_valid(i_valid),
        .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_d(i_d),
        .o_valid(ov[2]), .o_a(oa[2]), .o_b(ob[2]), .o_c(oc[2]), .o_d(od[2]));

    md5_step_stage #(.ROUND(48), .T_CONST(32'hf4292244), .LROT_BITS(6)) u_r48 (
        .clk(clk), .reset(reset), .message(message), .i_valid(i_valid),
        .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_d(i_d),
        .o_valid(ov[3]), .o_a(oa[3]), .o_b(ob[3]), .o_c(oc[3]), .o_d(od[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One MD5 step on (A,B,C,D): returns next {A,B,C,D}.
    function automatic logic [127:0] md5_ref(input int r, input logic [31:0] t, input int s,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input logic [31:0] d,
                                             input logic [31:0] m);
        logic [31:0] f, sum, rot;
        case (r / 16)
            0:       f = (b & c) | (~b & d);
            1:       f = (d & b) | (~d & c);
            2:       f = b ^ c ^ d;
            default: f = c ^ (b | ~d);
        endcase
        sum = a + f + m + t;
        rot = (sum << s) | (sum >> (32 - s));
        return {d, b + rot, b, c};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            ev[k] = 1'b0; ea[k] = '0; eb[k] = '0; ec[k] = '0; ed[k] = '0;
        end
    endtask

    // Advance one clock: model captures inputs at the edge, return at the next negedge.
    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (i_valid)
                {ea[k], eb[k], ec[k], ed[k]} = md5_ref(RND[k], TC[k], SH[k], i_a, i_b, i_c, i_d, message);
            ev[k] = i_valid;
        end
        @(negedge clk);
    endtask

    task automatic drive_rand(input logic v);
        i_valid = v;
        i_a = $urandom; i_b = $urandom; i_c = $urandom; i_d = $urandom;
        message = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b0; i_valid = 1'b1;
        i_a = '1; i_b = '1; i_c = '1; i_d = '1; message = '1;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            vectors++;
            if ({ov[k], oa[k], ob[k], oc[k], od[k]} !== 129'd0) begin
                miscompares++;
                $display("FAIL reset r%0d got v=%0b %h %h %h %h want all zero",
                         RND[k], ov[k], oa[k], ob[k], oc[k], od[k]);
            end
        end
        i_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abc();
        i_valid = 1'b1; message = 32'h80636261;
        i_a = 32'h67452301; i_b = 32'hefcdab89; i_c = 32'h98badcfe; i_d = 32'h10325476;
        cycle();
        vectors++;
        if ({ov[0], oa[0], ob[0], oc[0], od[0]} !== {1'b1, 32'h10325476, 32'hd6d117b4, 32'hefcdab89, 32'h98badcfe}) begin
            miscompares++;
            $display("FAIL abc_r0 got v=%0b %h %h %h %h want v=1 10325476 d6d117b4 efcdab89 98badcfe",
                     ov[0], oa[0], ob[0], oc[0], od[0]);
        end
        i_valid = 1'b0;
    endtask

    task automatic test_zero_rounds();
        logic [31:0] want_b [NI];
        want_b = '{32'h0, 32'hc3c4ac5e, 32'hffa3942f, 32'h0a4890fd};
        i_valid = 1'b1; message = '0; i_a = '0; i_b = '0; i_c = '0; i_d = '0;
        cycle();
        for (int k = 1; k < NI; k++) begin
            vectors++;
            if ({ov[k], oa[k], ob[k], oc[k], od[k]} !== {1'b1, 32'h0, want_b[k], 32'h0, 32'h0}) begin
                miscompares++;
                $display("FAIL zero_r%0d got v=%0b a=%h b=%h c=%h d=%h want v=1 b=%h others 0",
                         RND[k], ov[k], oa[k], ob[k], oc[k], od[k], want_b[k]);
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            drive_rand(n < 3);
            cycle();
            for (int k = 0; k < NI; k++) begin
                vectors++;
                if ({ov[k], oa[k], ob[k], oc[k], od[k]} !== {ev[k], ea[k], eb[k], ec[k], ed[k]}) begin
                    miscompares++;
                    $display("FAIL b2b_r%0d n=%0d got v=%0b %h %h %h %h want v=%0b %h %h %h %h",
                             RND[k], n, ov[k], oa[k], ob[k], oc[k], od[k], ev[k], ea[k], eb[k], ec[k], ed[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            drive_rand(($urandom_range(0, 3) != 0));
            cycle();
            for (int k = 0; k < NI; k++) begin
                vectors++;
                if ({ov[k], oa[k], ob[k], oc[k], od[k]} !== {ev[k], ea[k], eb[k], ec[k], ed[k]}) begin
                    miscompares++;
                    $display("FAIL rand_r%0d n=%0d got v=%0b %h %h %h %h want v=%0b %h %h %h %h",
                             RND[k], n, ov[k], oa[k], ob[k], oc[k], od[k], ev[k], ea[k], eb[k], ec[k], ed[k]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive_rand(1'b1);
        cycle();
        drive_rand(1'b1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NI; k++) begin
            vectors++;
            if ({ov[k], oa[k], ob[k], oc[k], od[k]} !== 129'd0) begin
                miscompares++;
                $display("FAIL async_rst_r%0d got v=%0b %h %h %h %h want all zero",
                         RND[k], ov[k], oa[k], ob[k], oc[k], od[k]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        drive_rand(1'b1);
        #1;
        for (int k = 0; k < NI; k++) begin
            vectors++;
            if (ov[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL post_rst_idle_r%0d got o_valid=%0b want 0", RND[k], ov[k]);
            end
        end
        @(negedge clk);
        cycle();
        for (int k = 0; k < NI; k++) begin
            vectors++;
            if ({ov[k], oa[k], ob[k], oc[k], od[k]} !== {1'b1, ea[k], eb[k], ec[k], ed[k]}) begin
                miscompares++;
                $display("FAIL post_rst_first_r%0d got v=%0b %h %h %h %h want v=1 %h %h %h %h",
                         RND[k], ov[k], oa[k], ob[k], oc[k], od[k], ea[k], eb[k], ec[k], ed[k]);
            end
        end
        i_valid = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0; i_valid = 1'b0;
        i_a = '0; i_b = '0; i_c = '0; i_d = '0; message = '0;
        @(negedge clk);
        test_reset();
        test_abc();
        test_zero_rounds();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
